// File: rtl/kmeans_k3n5_centroid_update_pkg.sv
// Shared definitions for the k-means (K=3, N=5) centroid update block:
// cluster/dimension counts, FSM state encoding and accumulator width helpers.
package kmeans_k3n5_centroid_update_pkg;

    // Number of clusters and number of coordinates per point.
    localparam int K = 3;
    localparam int N = 5;

    // Top-level controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_DIV  = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A per-cluster coordinate sum must hold qty * max_coordinate without overflow.
    function automatic int sum_width(input int data_w, input int qty_bit_w);
        return data_w + qty_bit_w;
    endfunction

    // A per-cluster count must reach qty itself, hence one extra bit.
    function automatic int cnt_width(input int qty_bit_w);
        return qty_bit_w + 1;
    endfunction

endpackage

// File: rtl/kmeans_k3n5_centroid_update_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, dividend_width
// cycles from start to done. The dividend register doubles as the quotient
// register (dividend bits shift out of the top, quotient bits shift in at the
// bottom). The caller guarantees a non-zero divisor.
module kmeans_seq_divider #(
    parameter int dividend_width = 16,
    parameter int divisor_width  = 9,
    parameter int quotient_width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [dividend_width-1:0] dividend,
    input  logic [divisor_width-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [quotient_width-1:0] quotient
);

    localparam int iter_w = $clog2(dividend_width + 1);

    logic [dividend_width-1:0] dq_q, dq_d;
    logic [divisor_width-1:0]  rem_q, rem_d;
    logic [divisor_width-1:0]  dvs_q, dvs_d;
    logic [iter_w-1:0]         iter_q, iter_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [divisor_width:0]    trial_s;
    logic [divisor_width:0]    diff_s;

    // One restoring step per busy cycle; a start loads operands when idle.
    always_comb begin
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trial_s = {rem_q, dq_q[dividend_width-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        if (busy_q) begin
            if (trial_s >= {1'b0, dvs_q}) begin
                rem_d = diff_s[divisor_width-1:0];
                dq_d  = {dq_q[dividend_width-2:0], 1'b1};
            end else begin
                rem_d = trial_s[divisor_width-1:0];
                dq_d  = {dq_q[dividend_width-2:0], 1'b0};
            end
            iter_d = iter_q - iter_w'(1);
            if (iter_q == iter_w'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start) begin
            dq_d   = dividend;
            dvs_d  = divisor;
            rem_d  = '0;
            iter_d = iter_w'(dividend_width);
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dq_q[quotient_width-1:0];

endmodule

// File: rtl/kmeans_k3n5_centroid_update.sv
// K-means centroid update for 3 clusters x 5 dimensions. Accumulates labelled
// points per cluster, then computes floor(sum / count) for each of the 15
// centroid coordinates with one shared sequential divider and streams them out
// cluster-major over a valid/ready handshake. Empty clusters are flagged.
module kmeans_k3n5_centroid_update
    import kmeans_k3n5_centroid_update_pkg::*;
#(
    parameter int data_width               = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int input_data_qty           = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_cluster,
    input  logic [data_width-1:0] in_d0,
    input  logic [data_width-1:0] in_d1,
    input  logic [data_width-1:0] in_d2,
    input  logic [data_width-1:0] in_d3,
    input  logic [data_width-1:0] in_d4,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_cluster,
    output logic [2:0]            out_dim,
    output logic [data_width-1:0] out_data,
    output logic                  out_empty,
    output logic                  busy,
    output logic                  done
);

    localparam int sum_w = sum_width(data_width, input_data_qty_bit_width);
    localparam int cnt_w = cnt_width(input_data_qty_bit_width);

    state_t state_q, state_d;

    logic [sum_w-1:0]      sum_q [K][N];
    logic [sum_w-1:0]      sum_d [K][N];
    logic [cnt_w-1:0]      cnt_q [K];
    logic [cnt_w-1:0]      cnt_d [K];
    logic [cnt_w-1:0]      pt_cnt_q, pt_cnt_d;
    logic [1:0]            cl_q, cl_d;
    logic [2:0]            dim_q, dim_d;
    logic                  div_started_q, div_started_d;

    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            out_cluster_q, out_cluster_d;
    logic [2:0]            out_dim_q, out_dim_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic                  out_empty_q, out_empty_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [data_width-1:0] point_s [N];
    logic                  xfer_s;
    logic                  div_start_s;
    logic                  div_busy_s;
    logic                  div_done_s;
    logic [sum_w-1:0]      div_dividend_s;
    logic [cnt_w-1:0]      div_divisor_s;
    logic [data_width-1:0] div_quot_s;

    // Gather the point coordinates into an indexable array.
    always_comb begin
        point_s[0] = in_d0;
        point_s[1] = in_d1;
        point_s[2] = in_d2;
        point_s[3] = in_d3;
        point_s[4] = in_d4;
    end

    assign xfer_s = in_valid && in_ready_q;

    // Divider operands follow the coordinate currently being resolved.
    always_comb begin
        div_dividend_s = sum_q[cl_q][dim_q];
        div_divisor_s  = cnt_q[cl_q];
    end

    kmeans_seq_divider #(
        .dividend_width (sum_w),
        .divisor_width  (cnt_w),
        .quotient_width (data_width)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Controller next-state, accumulation and output-register logic.
    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        pt_cnt_d      = pt_cnt_q;
        cl_d          = cl_q;
        dim_d         = dim_q;
        div_started_d = div_started_q;
        out_valid_d   = out_valid_q;
        out_cluster_d = out_cluster_q;
        out_dim_d     = out_dim_q;
        out_data_d    = out_data_q;
        out_empty_d   = out_empty_q;
        done_d        = 1'b0;
        div_start_s   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    for (int c = 0; c < K; c++) begin
                        cnt_d[c] = '0;
                        for (int k = 0; k < N; k++) begin
                            sum_d[c][k] = '0;
                        end
                    end
                    pt_cnt_d      = '0;
                    cl_d          = 2'd0;
                    dim_d         = 3'd0;
                    div_started_d = 1'b0;
                    state_d       = ST_ACC;
                end else begin
                    state_d = state_q;
                end
            end

            ST_ACC: begin
                if (xfer_s) begin
                    // Label 3 still counts as a transfer but contributes nothing.
                    if (in_cluster != 2'd3) begin
                        for (int k = 0; k < N; k++) begin
                            sum_d[in_cluster][k] = sum_q[in_cluster][k] + sum_w'(point_s[k]);
                        end
                        cnt_d[in_cluster] = cnt_q[in_cluster] + cnt_w'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    pt_cnt_d = pt_cnt_q + cnt_w'(1);
                    if (in_last || (pt_cnt_d == cnt_w'(input_data_qty))) begin
                        cl_d          = 2'd0;
                        dim_d         = 3'd0;
                        div_started_d = 1'b0;
                        state_d       = ST_DIV;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end

            ST_DIV: begin
                if (cnt_q[cl_q] == '0) begin
                    // Nothing to divide: report an empty cluster straight away.
                    out_valid_d   = 1'b1;
                    out_empty_d   = 1'b1;
                    out_data_d    = '0;
                    out_cluster_d = cl_q;
                    out_dim_d     = dim_q;
                    state_d       = ST_EMIT;
                end else if (!div_started_q) begin
                    if (!div_busy_s) begin
                        div_start_s   = 1'b1;
                        div_started_d = 1'b1;
                    end else begin
                        div_started_d = 1'b0;
                    end
                end else if (div_done_s) begin
                    out_valid_d   = 1'b1;
                    out_empty_d   = 1'b0;
                    out_data_d    = div_quot_s;
                    out_cluster_d = cl_q;
                    out_dim_d     = dim_q;
                    div_started_d = 1'b0;
                    state_d       = ST_EMIT;
                end else begin
                    state_d = ST_DIV;
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if ((cl_q == 2'd2) && (dim_q == 3'd4)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (dim_q == 3'd4) begin
                        dim_d   = 3'd0;
                        cl_d    = cl_q + 2'd1;
                        state_d = ST_DIV;
                    end else begin
                        dim_d   = dim_q + 3'd1;
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_ACC);
        busy_d     = (state_d == ST_ACC) || (state_d == ST_DIV) || (state_d == ST_EMIT);
    end

    // State, accumulator and output registers; reset abandons any pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int c = 0; c < K; c++) begin
                cnt_q[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    sum_q[c][k] <= '0;
                end
            end
            pt_cnt_q      <= '0;
            cl_q          <= 2'd0;
            dim_q         <= 3'd0;
            div_started_q <= 1'b0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_cluster_q <= 2'd0;
            out_dim_q     <= 3'd0;
            out_data_q    <= '0;
            out_empty_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            pt_cnt_q      <= pt_cnt_d;
            cl_q          <= cl_d;
            dim_q         <= dim_d;
            div_started_q <= div_started_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_cluster_q <= out_cluster_d;
            out_dim_q     <= out_dim_d;
            out_data_q    <= out_data_d;
            out_empty_q   <= out_empty_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_cluster = out_cluster_q;
    assign out_dim     = out_dim_q;
    assign out_data    = out_data_q;
    assign out_empty   = out_empty_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_kmeans_k3n5_centroid_update.sv
// Scoreboard bench for kmeans_k3n5_centroid_update: stimulus pushes the
// expected 15 centroid coordinates (plain per-cluster sums and floor division)
// into a queue, and an independent monitor pops and compares every output
// transfer, also checking that held outputs stay stable under backpressure.
`timescale 1ns/1ps
module tb_kmeans_k3n5_centroid_update;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_cluster;
    logic [7:0] in_d0, in_d1, in_d2, in_d3, in_d4;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_cluster;
    logic [2:0] out_dim;
    logic [7:0] out_data;
    logic       out_empty;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    kmeans_k3n5_centroid_update dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_cluster(in_cluster),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3), .in_d4(in_d4),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_cluster(out_cluster),
        .out_dim(out_dim), .out_data(out_data), .out_empty(out_empty),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [1:0] cl;
        logic [2:0] dim;
        logic [7:0] data;
        logic       emp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   m_sum [3][5];
    int   m_cnt [3];
    int   pop_cnt  = 0;
    int   done_cnt = 0;
    int   bp_mode  = 0;   // 0: always ready, 1: random, 2: never ready
    bit   hold_pend = 1'b0;
    exp_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Consumer-side backpressure.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each output transfer with the scoreboard head.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (out_valid) begin
                cur = '{cl: out_cluster, dim: out_dim, data: out_data, emp: out_empty};
                if (hold_pend) check("hold_stable", 32'(cur), 32'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        pop_cnt++;
                        check($sformatf("out_c%0dd%0d", e.cl, e.dim), 32'(cur), 32'(e));
                    end
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    held      = cur;
                end
            end else begin
                if (hold_pend) fail_now("valid_dropped_before_transfer");
                hold_pend = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},    32'(in_ready),    32'd0);
        check({tag, "_out_valid"},   32'(out_valid),   32'd0);
        check({tag, "_out_cluster"}, 32'(out_cluster), 32'd0);
        check({tag, "_out_dim"},     32'(out_dim),     32'd0);
        check({tag, "_out_data"},    32'(out_data),    32'd0);
        check({tag, "_out_empty"},   32'(out_empty),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
    endtask

    task automatic begin_pass();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            for (int k = 0; k < 5; k++) m_sum[c][k] = 0;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_point(input logic [1:0] cl, input logic [39:0] dv, input logic last);
        int waited = 0;
        bit ok = 1'b1;
        in_valid   = 1'b1;
        in_cluster = cl;
        in_d0 = dv[7:0];   in_d1 = dv[15:8];  in_d2 = dv[23:16];
        in_d3 = dv[31:24]; in_d4 = dv[39:32];
        in_last = last;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 64) begin
                fail_now("in_ready_timeout");
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok && (cl != 2'd3)) begin
            m_cnt[cl]++;
            for (int k = 0; k < 5; k++) m_sum[cl][k] += int'(dv[8*k +: 8]);
        end
    endtask

    function automatic logic [39:0] rand_point(input int hi);
        logic [39:0] v;
        for (int k = 0; k < 5; k++) v[8*k +: 8] = 8'($urandom_range(0, hi));
        return v;
    endfunction

    task automatic push_expected();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (m_cnt[c] == 0)
                    exp_q.push_back('{cl: 2'(c), dim: 3'(k), data: 8'd0, emp: 1'b1});
                else
                    exp_q.push_back('{cl: 2'(c), dim: 3'(k), data: 8'(m_sum[c][k] / m_cnt[c]), emp: 1'b0});
            end
        end
    endtask

    task automatic wait_done(input string tag, input int pre);
        int t = 0;
        while ((done_cnt == pre) && (t < 30000)) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == pre) fail_now({tag, "_done_timeout"});
        cyc(3);
        check({tag, "_done_once"},   32'(done_cnt),   32'(pre + 1));
        check({tag, "_sb_drained"},  32'(exp_q.size()), 32'd0);
        check({tag, "_busy_idle"},   32'(busy),       32'd0);
        check({tag, "_in_ready_lo"}, 32'(in_ready),   32'd0);
        exp_q.delete();
    endtask

    task automatic end_pass(input string tag);
        int pre = done_cnt;
        push_expected();
        wait_done(tag, pre);
    endtask

    // Watchdog against any unbounded stall.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pre;
        int t;
        logic [1:0] cl;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_cluster = 2'd0; in_last = 1'b0;
        in_d0 = 8'd0; in_d1 = 8'd0; in_d2 = 8'd0; in_d3 = 8'd0; in_d4 = 8'd0;
        cyc(3);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // in_valid without start is ignored
        in_valid = 1'b1; in_cluster = 2'd0; in_d0 = 8'd99;
        cyc(4);
        check("no_start_in_ready", 32'(in_ready), 32'd0);
        check("no_start_busy",     32'(busy),     32'd0);
        in_valid = 1'b0;
        cyc(1);

        // four points to cluster 1
        begin_pass();
        check("acc_busy", 32'(busy), 32'd1);
        send_point(2'd1, {8'd4, 8'd3, 8'd2, 8'd1, 8'd10}, 1'b0);
        send_point(2'd1, {8'd8, 8'd6, 8'd4, 8'd2, 8'd20}, 1'b0);
        send_point(2'd1, {8'd0, 8'd9, 8'd6, 8'd3, 8'd30}, 1'b0);
        send_point(2'd1, {8'd1, 8'd0, 8'd7, 8'd5, 8'd41}, 1'b1);
        end_pass("four_pts");

        // zero-point pass
        begin_pass();
        send_point(2'd3, rand_point(255), 1'b1);
        end_pass("zero_pts");

        // 256 maximal points without in_last
        begin_pass();
        for (int i = 0; i < 256; i++) send_point(2'd0, {5{8'd255}}, 1'b0);
        check("qty_limit_in_ready", 32'(in_ready), 32'd0);
        check("qty_limit_busy",     32'(busy),     32'd1);
        end_pass("qty_limit");

        // long backpressure on the first output, start ignored while busy
        bp_mode = 2;
        begin_pass();
        for (int i = 0; i < 12; i++) send_point(2'($urandom_range(0, 2)), rand_point(255), (i == 11));
        pre = done_cnt;
        push_expected();
        t = 0;
        while (!out_valid && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            if (i == 10) start = 1'b1;
            if (i == 11) start = 1'b0;
        end
        bp_mode = 0;
        wait_done("backpressure", pre);

        // start pulses and label-3 points mixed into accumulation
        bp_mode = 1;
        begin_pass();
        for (int i = 0; i < 40; i++) begin
            cl = ((i % 3) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            send_point(cl, rand_point(255), (i == 39));
            if ((i == 10) || (i == 25)) begin
                start = 1'b1;
                cyc(1);
                start = 1'b0;
            end
        end
        end_pass("start_ignored");

        // reset while dividing c1d2, then a clean pass
        bp_mode = 0;
        begin_pass();
        for (int i = 0; i < 9; i++) send_point(2'(i % 3), rand_point(255), (i == 8));
        push_expected();
        pre = pop_cnt;
        t = 0;
        while ((pop_cnt < pre + 7) && (t < 2000)) begin
            @(negedge clk);
            t++;
        end
        if (pop_cnt < pre + 7) fail_now("reach_c1d2_timeout");
        cyc(2);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("mid_reset");
        cyc(2);
        rst = 1'b0;
        cyc(4);
        check("post_reset_waits", 32'(in_ready), 32'd0);
        begin_pass();
        for (int i = 0; i < 6; i++) send_point(2'(i % 2), rand_point(50), (i == 5));
        end_pass("after_reset");

        // random passes with random backpressure
        bp_mode = 1;
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(1, 256);
            begin_pass();
            for (int i = 0; i < n; i++)
                send_point(2'($urandom_range(0, 3)), rand_point((p == 1) ? 15 : 255), (i == n - 1));
            end_pass($sformatf("random%0d", p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/kmeans_k3n5_centroid_update.md
KMEANS_K3N5_CENTROID_UPDATE -- requirements
Module: kmeans_k3n5_centroid_update

Interface
REQ-001 Parameter data_width, default 8: bits per point coordinate and per centroid coordinate.
REQ-002 Parameter input_data_qty_bit_width, default 8: bits of the per-pass point index.
REQ-003 Parameter input_data_qty, default 256: maximum points accepted per pass.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a pass; ignored unless the block is in IDLE or DONE.
REQ-007 in_valid  input  1  a labelled point is presented.
REQ-008 in_ready  output  1  high only in ACC; a point transfers on in_valid && in_ready.
REQ-009 in_cluster  input  2  nearest-centroid label, 0..2; value 3 is consumed and discarded.
REQ-010 in_d0..in_d4  input  data_width each  point coordinates, unsigned.
REQ-011 in_last  input  1  marks the final point of the pass; sampled with the transfer.
REQ-012 out_valid  output  1  a new centroid coordinate is presented.
REQ-013 out_ready  input  1  consumer accepts; a coordinate transfers on out_valid && out_ready.
REQ-014 out_cluster  output  2  centroid index of the presented coordinate.
REQ-015 out_dim  output  3  dimension index of the presented coordinate, 0..4.
REQ-016 out_data  output  data_width  new coordinate value.
REQ-017 out_empty  output  1  the cluster received 0 points; out_data = 0; consumer keeps its old value.
REQ-018 busy  output  1  high in ACC, DIV and EMIT.
REQ-019 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-020 FSM states: IDLE, ACC, DIV, EMIT, DONE.
REQ-021 IDLE/DONE + start -> clear all sums, counts and the point counter -> ACC.
REQ-022 ACC: each transfer adds in_dk to sum[in_cluster][k] and increments cnt[in_cluster] in the same cycle.
REQ-023 Sum width = data_width + input_data_qty_bit_width; count width = input_data_qty_bit_width + 1; no overflow possible within input_data_qty points.
REQ-024 ACC -> DIV on the cycle after a transfer with in_last = 1, or after the input_data_qty-th transfer, whichever comes first.
REQ-025 DIV: cluster-major, dimension-minor order (c0d0..c0d4, c1d0..c2d4); each quotient = floor(sum / cnt), computed by an iterative restoring divider.
REQ-026 Divider latency: exactly sum-width cycles per quotient (16 at default); the quotient is truncated to data_width bits, which is lossless because the quotient is <= max coordinate.
REQ-027 cnt = 0: the division is skipped (0 cycles); the result is flagged empty with data 0.
REQ-028 After each quotient -> EMIT; out_valid is held with stable fields until out_ready; a transfer returns the block to DIV for the next coordinate, or to DONE after c2d4.
REQ-029 out_ready may be low indefinitely; there is no timeout, and no data is dropped.
REQ-030 start while busy is ignored; in_valid outside ACC is ignored (in_ready = 0).
REQ-031 A pass of 0 points is a start followed by in_last on the first transfer with in_cluster = 3: all 15 outputs are emitted with out_empty = 1.

Reset
REQ-032 Asserting rst at any time, including mid-pass, forces IDLE within the same edge-independent event: in_ready = 0, out_valid = 0, out_cluster = 0, out_dim = 0, out_data = 0, out_empty = 0, busy = 0, done = 0, and all sums, counts and the divider cleared.
REQ-033 After rst deasserts, the block waits for start; no partial pass resumes.

Structure
REQ-034 The shared package holds the FSM state encoding, K = 3, N = 5, and the sum/count width derivation functions.
REQ-035 One sub-module, kmeans_seq_divider: start/busy/done handshake, parameterised dividend/divisor widths, restoring algorithm.
REQ-036 sum[3][5] and cnt[3] are registers, not memory; the divider is shared by all 15 quotients.

Verification
REQ-037 Four points to cluster 1, d0 = 10,20,30,41, in_last on the 4th -> c1d0 = 25; clusters 0 and 2 have out_empty = 1 and out_data = 0.
REQ-038 256 points of 255 to cluster 0 with no in_last -> ACC ends after the 256th point; c0d0..d4 = 255; in_ready drops.
REQ-039 out_ready held low 100 cycles during the first EMIT -> out_valid stays high with stable fields; all 15 outputs are then emitted in order and done pulses once.
REQ-040 rst asserted while in DIV for c1d2 -> all outputs are 0 next sample; a later start with new data produces correct results with no carry-over.
REQ-041 start pulsed during ACC and in_cluster = 3 points interleaved -> sums and counts are unaffected; results match a reference model.
REQ-042 A constrained-random 1..256 point pass checked against a floor-division model, with random out_ready backpressure.
